// File: rtl/tone_pkg.sv
// Shared types and default widths for the tone/burst buzzer generator.
package tone_pkg;

    localparam int DEF_DIV_W = 26;
    localparam int DEF_CAD_W = 24;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_CONT  = 1'b0,
        MODE_BURST = 1'b1
    } mode_e;

endpackage

// File: rtl/tone_osc.sv
// Tone oscillator: half-period divider with toggle output, or (with
// TONE_BURST_DUTY_EN defined) a full-period counter with duty comparator.
// clr has priority over en and forces the counter and bz to zero.
module tone_osc
    import tone_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
`ifdef TONE_BURST_DUTY_EN
    input  logic [DIV_W:0]   duty,
`endif
    output logic             bz
);

`ifdef TONE_BURST_DUTY_EN
    logic [DIV_W:0] pcnt;
    logic [DIV_W:0] pcnt_nxt;
    logic [DIV_W:0] pmax;

    // Full period is 2*div+2 cycles, so the counter wraps at 2*div+1.
    assign pmax = {div, 1'b1};

    // Next value of the period counter, wrapping at the end of the period.
    always_comb begin
        pcnt_nxt = pcnt + 1'b1;
        if (pcnt == pmax) begin
            pcnt_nxt = {(DIV_W+1){1'b0}};
        end
    end

    // Period counter and registered duty comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            bz   <= 1'b0;
        end else if (clr) begin
            pcnt <= '0;
            bz   <= 1'b0;
        end else if (en) begin
            pcnt <= pcnt_nxt;
            bz   <= (pcnt_nxt < duty);
        end
    end
`else
    logic [DIV_W-1:0] cnt;

    // Half-period counter; bz toggles each time it reaches div.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            bz  <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            bz  <= 1'b0;
        end else if (en) begin
            if (cnt == div) begin
                cnt <= '0;
                bz  <= ~bz;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/tone_burst_gen.sv
// Buzzer tone generator with optional on/off burst cadence and a
// start/stop/done handshake. Optional duty control is enabled by defining
// TONE_BURST_DUTY_EN, which adds the duty input latched at start.
module tone_burst_gen
    import tone_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W,
    parameter int CAD_W = DEF_CAD_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [DIV_W-1:0] div,
    input  logic [CAD_W-1:0] on_len,
    input  logic [CAD_W-1:0] off_len,
    input  logic [CNT_W-1:0] count,
`ifdef TONE_BURST_DUTY_EN
    input  logic [DIV_W:0]   duty,
`endif
    output logic             bz,
    output logic             busy,
    output logic             done
);

    state_e           state;
    mode_e            mode_sh;
    logic [DIV_W-1:0] div_sh;
    logic [CAD_W-1:0] on_sh;
    logic [CAD_W-1:0] off_sh;
    logic [CNT_W-1:0] count_sh;
`ifdef TONE_BURST_DUTY_EN
    logic [DIV_W:0]   duty_sh;
`endif
    logic [CAD_W-1:0] cad;
    logic [CNT_W-1:0] bursts;
    logic [CNT_W-1:0] bursts_inc;
    logic             on_end;
    logic             last_burst;
    logic             osc_clr;
    logic             osc_en;

    // Phase-end and completion decode for the burst cadence.
    always_comb begin
        bursts_inc = bursts + 1'b1;
        on_end     = (state == ON) && (mode_sh == MODE_BURST) && (cad == on_sh);
        last_burst = on_end && (count_sh != '0) && (bursts_inc == count_sh);
        // The oscillator only runs in ON; every phase boundary restarts it at 0.
        osc_clr    = (state != ON) || stop || on_end;
        osc_en     = (state == ON);
    end

    // Control FSM with cadence and burst counters; stop overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_sh  <= MODE_CONT;
            div_sh   <= '0;
            on_sh    <= '0;
            off_sh   <= '0;
            count_sh <= '0;
`ifdef TONE_BURST_DUTY_EN
            duty_sh  <= '0;
`endif
            cad      <= '0;
            bursts   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state  <= IDLE;
                cad    <= '0;
                bursts <= '0;
                busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            mode_sh  <= mode_e'(mode);
                            div_sh   <= div;
                            on_sh    <= on_len;
                            off_sh   <= off_len;
                            count_sh <= count;
`ifdef TONE_BURST_DUTY_EN
                            duty_sh  <= duty;
`endif
                            cad      <= '0;
                            bursts   <= '0;
                            state    <= ON;
                            busy     <= 1'b1;
                        end
                    end
                    ON: begin
                        if (mode_sh == MODE_BURST) begin
                            if (cad == on_sh) begin
                                cad <= '0;
                                // Saturate so an unlimited run never wraps.
                                if (bursts != '1) begin
                                    bursts <= bursts_inc;
                                end
                                if (last_burst) begin
                                    state  <= IDLE;
                                    busy   <= 1'b0;
                                    done   <= 1'b1;
                                    bursts <= '0;
                                end else if (off_sh == '0) begin
                                    state <= ON;
                                end else begin
                                    state <= OFF;
                                end
                            end else begin
                                cad <= cad + 1'b1;
                            end
                        end
                    end
                    OFF: begin
                        if (cad == off_sh) begin
                            cad   <= '0;
                            state <= ON;
                        end else begin
                            cad <= cad + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    tone_osc #(
        .DIV_W (DIV_W)
    ) u_osc (
        .clk  (clk),
        .rst  (rst),
        .clr  (osc_clr),
        .en   (osc_en),
        .div  (div_sh),
`ifdef TONE_BURST_DUTY_EN
        .duty (duty_sh),
`endif
        .bz   (bz)
    );

endmodule

// File: tb/tb_tone_burst_gen.sv
// Directed bench for tone_burst_gen (default build: TONE_BURST_DUTY_EN undefined).
module tb_tone_burst_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        mode;
    logic [25:0] div;
    logic [23:0] on_len;
    logic [23:0] off_len;
    logic [7:0]  count;
`ifdef TONE_BURST_DUTY_EN
    logic [26:0] duty;
`endif
    logic        bz;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] v_bz;
    logic [63:0] v_busy;
    logic [63:0] v_done;

    tone_burst_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .div     (div),
        .on_len  (on_len),
        .off_len (off_len),
        .count   (count),
`ifdef TONE_BURST_DUTY_EN
        .duty    (duty),
`endif
        .bz      (bz),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_vec();
        v_bz   = '0;
        v_busy = '0;
        v_done = '0;
    endtask

    task automatic record(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            tick(1);
            start = 1'b0;
            v_bz[k-first]   = bz;
            v_busy[k-first] = busy;
            v_done[k-first] = done;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
        div = '0; on_len = '0; off_len = '0; count = '0;
`ifdef TONE_BURST_DUTY_EN
        duty = '0;
`endif
        tick(2);
        chk("reset_bz", {63'd0, bz}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        tick(1);

        // Continuous tone, div=3: period 8, first rise 4 edges after start.
        mode = 1'b0; div = 26'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("cont_busy_start", {63'd0, busy}, 64'd1);
        chk("cont_bz_start", {63'd0, bz}, 64'd0);
        clear_vec();
        record(1, 16);
        chk("cont_bz_wave", v_bz, 64'h7878);
        chk("cont_busy_hold", v_busy, 64'hFFFF);
        chk("cont_no_done", v_done, 64'h0);

        // Start while busy with a new div: must be ignored.
        div = 26'd0; start = 1'b1;
        clear_vec();
        record(17, 24);
        chk("busy_start_ignored", v_bz, 64'h78);
        tick(4);
        chk("cont_bz_high", {63'd0, bz}, 64'd1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop_bz", {63'd0, bz}, 64'd0);
        chk("stop_busy", {63'd0, busy}, 64'd0);
        chk("stop_done", {63'd0, done}, 64'd0);
        tick(1);
        chk("stop_no_done_later", {63'd0, done}, 64'd0);

        // stop and start together in IDLE: stays idle.
        start = 1'b1; stop = 1'b1;
        tick(1);
        start = 1'b0; stop = 1'b0;
        chk("stop_start_idle_busy", {63'd0, busy}, 64'd0);
        tick(2);
        chk("stop_start_idle_later", {62'd0, busy, bz}, 64'd0);

        // Burst: div=1, on_len=9, off_len=4, count=3.
        mode = 1'b1; div = 26'd1; on_len = 24'd9; off_len = 24'd4; count = 8'd3;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        clear_vec();
        record(1, 40);
        chk("burst_bz", v_bz, 64'h19_8033_0066);
        chk("burst_busy", v_busy, 64'h7F_FFFF_FFFF);
        chk("burst_done", v_done, 64'h80_0000_0000);

        // Start during the done cycle is accepted.
        mode = 1'b0; div = 26'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("start_in_done_busy", {63'd0, busy}, 64'd1);
        chk("start_in_done_pulse", {63'd0, done}, 64'd0);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        chk("stop2_busy", {63'd0, busy}, 64'd0);

        // Zero OFF length: two back-to-back 6-cycle ON phases.
        mode = 1'b1; div = 26'd1; on_len = 24'd5; off_len = 24'd0; count = 8'd2;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        clear_vec();
        record(1, 12);
        chk("zoff_bz", v_bz, 64'h186);
        chk("zoff_busy", v_busy, 64'h7FF);
        chk("zoff_done", v_done, 64'h800);
        tick(1);
        chk("zoff_done_one_cycle", {63'd0, done}, 64'd0);

        // Reset asserted during an OFF phase.
        mode = 1'b1; div = 26'd1; on_len = 24'd3; off_len = 24'd5; count = 8'd0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        chk("off_busy", {63'd0, busy}, 64'd1);
        chk("off_bz", {63'd0, bz}, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("rst_off_outputs", {61'd0, bz, busy, done}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fresh run after reset, then reset while bz is high.
        mode = 1'b0; div = 26'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("fresh_busy", {63'd0, busy}, 64'd1);
        tick(3);
        chk("fresh_bz_low", {63'd0, bz}, 64'd0);
        tick(1);
        chk("fresh_bz_rise", {63'd0, bz}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_on_outputs", {61'd0, bz, busy, done}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(2);
        chk("post_rst_idle", {61'd0, bz, busy, done}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tone_burst_gen.md
# tone_burst_gen

Parametrised tone generator for the buzzer path: produces a square tone of programmable half-period, optionally gated into on/off bursts with a programmable burst count. Sits between the range/alert logic, which issues start/stop commands with tone and cadence settings, and the buzzer pin. Successor to the single-key fixed tone divider: adds configurable widths, a cadence/burst mode, a start/stop/done handshake, and optional duty control.

## Interface
- `DIV_W`, default 26: width of the tone half-period divider.
- `CAD_W`, default 24: width of the on/off cadence lengths, in clock cycles.
- `CNT_W`, default 8: width of the burst count.
- `clk`  in  1  system clock; one clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request pulse; accepted only in IDLE.
- `stop`  in  1  abort; honoured in any state.
- `mode`  in  1  0 = continuous tone, 1 = burst cadence.
- `div`  in  DIV_W  tone half-period minus one.
- `on_len`, `off_len`  in  CAD_W  ON/OFF phase length minus one.
- `count`  in  CNT_W  number of bursts; 0 = unlimited.
- `bz`  out  1  buzzer drive, registered.
- `busy`  out  1  high in ON or OFF.
- `done`  out  1  one-cycle pulse on natural completion.

## Operation
- States: IDLE, ON, OFF. Reset and IDLE: bz=0, busy=0, done=0, all counters 0.
- IDLE + start + !stop: latch div, on_len, off_len, count, and mode into shadow registers; go to ON; clear tone, cadence, and burst counters. Input changes during a run are ignored.
- ON: tone counter increments. When it equals shadow div: counter←0, bz←~bz. Half-period = div+1 cycles; div=0 toggles every cycle.
- ON, continuous mode: cadence is ignored. Remain in ON until stop.
- ON, burst mode: cadence counter increments. When it equals on_len (phase of on_len+1 cycles), bursts←bursts+1 and then:
  - if count≠0 and bursts+1==count: go to IDLE, done←1, bz←0;
  - else if off_len==0: restart ON (cadence and tone counters←0, bz←0), no OFF cycle;
  - else: go to OFF, bz←0.
- OFF: bz held 0. Cadence counter counts to off_len, then go to ON with counters cleared.
- stop (any state, wins over start and over completion in the same cycle): go to IDLE, bz←0, done stays 0.
- start while busy is ignored.
- Counters wrap-free. The burst counter saturates at all-ones when count=0.

## Timing
- start sampled at edge E: busy=1, state=ON after E; first bz rise at edge E+div+1.
- Completion at the edge ending the last ON phase: busy←0, bz←0, done=1 for exactly one cycle. A start in the done cycle is accepted (the FSM is in IDLE).
- stop sampled at edge E: bz=0, busy=0 after E.
- Reset asserted mid-run: outputs go to reset values asynchronously; no done pulse.

## Configuration
- `TONE_BURST_DUTY_EN` defined:
  - adds input `duty` [DIV_W:0], latched at start;
  - the tone uses a full-period counter of DIV_W+1 bits, counting 0..2·div+1;
  - bz = (pcnt < duty) during ON; duty ≥ 2·div+2 holds bz=1, and duty=0 holds bz=0.
- Not defined: 50% square wave as described in Operation, equivalent to duty=div+1.

## Structure
- Package `tone_pkg`: state enum (IDLE, ON, OFF), mode enum (MODE_CONT, MODE_BURST), default width localparams.
- Sub-module `tone_osc`: divider/toggle or duty comparator with a clear input, parametrised by DIV_W. The FSM, cadence counter, and burst counter live in tone_burst_gen.

## Test plan
- Continuous tone: mode=0, div=3, start → bz period of 8 cycles, first rise 4 cycles after the start edge, busy stays 1; stop → bz=0 and busy=0 next cycle, no done.
- Burst mode: mode=1, div=1, on_len=9, off_len=4, count=3 → three 10-cycle ON phases separated by 5-cycle OFF phases with bz=0; done pulses once, 1 cycle, at the end of burst 3.
- Zero OFF length: off_len=0, count=2, on_len=5 → two back-to-back 6-cycle ON phases with no OFF cycle, then done.
- Start while busy, with div changed mid-run → ignored, tone period unchanged. stop and start in the same cycle in IDLE → remains IDLE.
- Reset asserted in the middle of an OFF phase → bz, busy, and done are 0 immediately. A start after reset release behaves as a fresh run.
- TONE_BURST_DUTY_EN with div=3, duty=2 → bz high 2 of every 8 cycles. With duty=0, bz stays 0.
